pgr_mdio_slave_16bit: RTL and testbench

- Clause-22 MDIO responder: the PHY-side counterpart of the team's MDIO management master.
- Oversamples MDC/MDIO in the system clock domain and decodes read and write frames addressed to PHY_ADDR.
- Writes go out as single-cycle register write strobes; reads fetch register data and drive it back on MDIO.
- Used as a loopback responder in example designs and as a register front-end for soft PHY logic.

---
 rtl/pgr_mdio_slave_16bit_if.sv | 24 ++
 rtl/pgr_mdio_slave_16bit.sv | 230 +++++++++++++++++++++++
 tb/tb_pgr_mdio_slave_16bit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pgr_mdio_slave_16bit_if.sv
// Bus bundle for the Clause-22 MDIO responder: MDIO pad side plus the
// register-access side towards the soft PHY logic.
interface pgr_mdio_slave_16bit_if;
    logic        mdc;
    logic        mdi;
    logic        mdo;
    logic        mdo_en;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic        busy;

    modport slave (
        input  mdc, mdi, reg_rdata,
        output mdo, mdo_en, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output mdc, mdi, reg_rdata,
        input  mdo, mdo_en, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface

// File: rtl/pgr_mdio_slave_16bit.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO in the clk domain, decodes
// frames addressed to PHY_ADDR and turns them into register strobes.
module pgr_mdio_slave_16bit #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] TIMEOUT  = 16'd2000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pgr_mdio_slave_16bit_if.slave        bus
);
    typedef enum logic [2:0] {
        S_PRE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  meta_reg, sync_reg;          // [1] = mdc, [0] = mdi
    logic        mdc_d_reg;
    logic [5:0]  pre_cnt_reg, pre_cnt_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [1:0]  op_reg, op_next;
    logic [4:0]  addr_sh_reg, addr_sh_next;
    logic        match_reg, match_next;
    logic        discard_reg, discard_next;
    logic [15:0] data_sh_reg, data_sh_next;
    logic [15:0] idle_reg, idle_next;
    logic        mdo_reg, mdo_next;
    logic        mdo_en_reg, mdo_en_next;
    logic [4:0]  reg_addr_reg, reg_addr_next;
    logic [15:0] reg_wdata_reg, reg_wdata_next;
    logic        reg_we_reg, reg_we_next;
    logic        reg_re_reg, reg_re_next;
    logic        rd_pend_reg, rd_pend_next;
    logic        we_pend_reg, we_pend_next;

    logic        rise;
    logic        bit_s;
    logic        is_rd;
    logic        is_wr;
    logic        rd_match;

    assign rise     = sync_reg[1] & ~mdc_d_reg;
    assign bit_s    = sync_reg[0];
    assign is_rd    = (op_reg == 2'b10);
    assign is_wr    = (op_reg == 2'b01);
    assign rd_match = match_reg & is_rd;

    // Synchronisers idle high so a high MDC at reset release is not seen as a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg  <= 2'b11;
            sync_reg  <= 2'b11;
            mdc_d_reg <= 1'b1;
        end else begin
            meta_reg  <= {bus.mdc, bus.mdi};
            sync_reg  <= meta_reg;
            mdc_d_reg <= sync_reg[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_PRE;
            pre_cnt_reg   <= 6'd0;
            bit_cnt_reg   <= 4'd0;
            op_reg        <= 2'b00;
            addr_sh_reg   <= 5'd0;
            match_reg     <= 1'b0;
            discard_reg   <= 1'b0;
            data_sh_reg   <= 16'd0;
            idle_reg      <= 16'd0;
            mdo_reg       <= 1'b1;
            mdo_en_reg    <= 1'b0;
            reg_addr_reg  <= 5'd0;
            reg_wdata_reg <= 16'd0;
            reg_we_reg    <= 1'b0;
            reg_re_reg    <= 1'b0;
            rd_pend_reg   <= 1'b0;
            we_pend_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pre_cnt_reg   <= pre_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            op_reg        <= op_next;
            addr_sh_reg   <= addr_sh_next;
            match_reg     <= match_next;
            discard_reg   <= discard_next;
            data_sh_reg   <= data_sh_next;
            idle_reg      <= idle_next;
            mdo_reg       <= mdo_next;
            mdo_en_reg    <= mdo_en_next;
            reg_addr_reg  <= reg_addr_next;
            reg_wdata_reg <= reg_wdata_next;
            reg_we_reg    <= reg_we_next;
            reg_re_reg    <= reg_re_next;
            rd_pend_reg   <= rd_pend_next;
            we_pend_reg   <= we_pend_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pre_cnt_next   = pre_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        op_next        = op_reg;
        addr_sh_next   = addr_sh_reg;
        match_next     = match_reg;
        discard_next   = discard_reg;
        data_sh_next   = data_sh_reg;
        mdo_next       = mdo_reg;
        mdo_en_next    = mdo_en_reg;
        reg_addr_next  = reg_addr_reg;
        reg_wdata_next = reg_wdata_reg;
        rd_pend_next   = 1'b0;
        we_pend_next   = 1'b0;
        reg_re_next    = rd_pend_reg;
        reg_we_next    = we_pend_reg;
        idle_next      = rise ? 16'd0 :
                         ((idle_reg == 16'hFFFF) ? idle_reg : idle_reg + 16'd1);

        if (we_pend_reg) reg_wdata_next = data_sh_reg;
        // Read data is captured on the clk after the reg_re strobe
        if (reg_re_reg)  data_sh_next   = bus.reg_rdata;

        if ((state_reg != S_PRE) && (idle_reg >= TIMEOUT)) begin
            state_next   = S_PRE;
            pre_cnt_next = 6'd0;
            mdo_en_next  = 1'b0;
            mdo_next     = 1'b1;
        end else if (rise) begin
            case (state_reg)
                S_PRE: begin
                    if (bit_s) begin
                        pre_cnt_next = (pre_cnt_reg == 6'd63) ? pre_cnt_reg : pre_cnt_reg + 6'd1;
                    end else if (pre_cnt_reg >= 6'd32) begin
                        state_next   = S_ST2;
                        pre_cnt_next = 6'd0;
                    end else begin
                        pre_cnt_next = 6'd0;
                    end
                end
                S_ST2: begin
                    state_next   = bit_s ? S_OP : S_PRE;
                    bit_cnt_next = 4'd0;
                end
                S_OP: begin
                    op_next = {op_reg[0], bit_s};
                    if (bit_cnt_reg == 4'd1) begin
                        state_next   = S_PHYAD;
                        bit_cnt_next = 4'd0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                S_PHYAD: begin
                    addr_sh_next = {addr_sh_reg[3:0], bit_s};
                    if (bit_cnt_reg == 4'd4) begin
                        match_next   = ({addr_sh_reg[3:0], bit_s} == PHY_ADDR) && (is_rd || is_wr);
                        state_next   = S_REGAD;
                        bit_cnt_next = 4'd0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                S_REGAD: begin
                    addr_sh_next = {addr_sh_reg[3:0], bit_s};
                    if (bit_cnt_reg == 4'd4) begin
                        reg_addr_next = {addr_sh_reg[3:0], bit_s};
                        rd_pend_next  = rd_match;
                        discard_next  = 1'b0;
                        state_next    = S_TA;
                        bit_cnt_next  = 4'd0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_reg == 4'd0) begin
                        if (rd_match) begin
                            mdo_en_next = 1'b1;
                            mdo_next    = 1'b0;
                        end
                        if (is_wr && !bit_s) discard_next = 1'b1;
                        bit_cnt_next = 4'd1;
                    end else begin
                        if (rd_match) begin
                            mdo_next     = data_sh_reg[15];
                            data_sh_next = {data_sh_reg[14:0], 1'b0};
                        end
                        if (is_wr && bit_s) discard_next = 1'b1;
                        state_next   = S_DATA;
                        bit_cnt_next = 4'd0;
                    end
                end
                S_DATA: begin
                    if (rd_match) begin
                        if (bit_cnt_reg == 4'd15) begin
                            mdo_en_next = 1'b0;
                            mdo_next    = 1'b1;
                        end else begin
                            mdo_next     = data_sh_reg[15];
                            data_sh_next = {data_sh_reg[14:0], 1'b0};
                        end
                    end else begin
                        data_sh_next = {data_sh_reg[14:0], bit_s};
                    end
                    if (bit_cnt_reg == 4'd15) begin
                        we_pend_next = match_reg && is_wr && !discard_reg;
                        state_next   = S_PRE;
                        pre_cnt_next = 6'd0;
                        bit_cnt_next = 4'd0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_next   = S_PRE;
                    pre_cnt_next = 6'd0;
                end
            endcase
        end
    end

    assign bus.mdo       = mdo_reg;
    assign bus.mdo_en    = mdo_en_reg;
    assign bus.reg_addr  = reg_addr_reg;
    assign bus.reg_wdata = reg_wdata_reg;
    assign bus.reg_we    = reg_we_reg;
    assign bus.reg_re    = reg_re_reg;
    assign bus.busy      = (state_reg != S_PRE);
endmodule

// File: tb/tb_pgr_mdio_slave_16bit.sv
// Self-checking bench for pgr_mdio_slave_16bit: an MDIO master model drives
// frames against a loopback register file; a frame-level model predicts results.
module tb_pgr_mdio_slave_16bit;
    localparam logic [4:0] PHY = 5'd1;
    localparam int HALF = 200;               // 2.5 MHz MDC
    localparam int RD_EN_CYCLES = 17 * 20;   // TA[2]..D0 window in clk cycles

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;                   // 50 MHz

    pgr_mdio_slave_16bit_if tb_bus ();

    pgr_mdio_slave_16bit #(.PHY_ADDR(PHY), .TIMEOUT(16'd2000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tb_bus)
    );

    logic        master_oe;
    logic        master_bit;
    logic [15:0] phy_mem [32];
    logic        mem_ready = 1'b0;
    logic [15:0] model_mem [32];
    logic [4:0]  model_addr;
    int          we_cycles = 0;
    int          re_cycles = 0;
    int          en_cycles = 0;
    logic [4:0]  last_waddr = 5'd0;
    logic [15:0] last_wdata = 16'd0;
    int          tests_run = 0;
    int          tests_failed = 0;

    assign tb_bus.mdi       = master_oe ? master_bit : (tb_bus.mdo_en ? tb_bus.mdo : 1'b1);
    assign tb_bus.reg_rdata = phy_mem[tb_bus.reg_addr];

    function automatic logic [15:0] init_val(input int i);
        return 16'h5A00 ^ 16'(i * 16'h0931);
    endfunction

    // Loopback register file and strobe monitors, sampled away from the active edge
    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) phy_mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (tb_bus.reg_we) begin
            phy_mem[tb_bus.reg_addr] <= tb_bus.reg_wdata;
        end
        if (tb_bus.reg_we) begin
            we_cycles  <= we_cycles + 1;
            last_waddr <= tb_bus.reg_addr;
            last_wdata <= tb_bus.reg_wdata;
        end
        if (tb_bus.reg_re) re_cycles <= re_cycles + 1;
        if (tb_bus.mdo_en) en_cycles <= en_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic oe, input logic b, output logic s);
        master_oe  = oe;
        master_bit = b;
        #HALF;
        s = tb_bus.mdi;
        tb_bus.mdc = 1'b1;
        #HALF;
        tb_bus.mdc = 1'b0;
    endtask

    // Sends pre_len preamble ones then the first nbits of body; the master
    // releases the line from TA onward on read frames.
    task automatic send_frame(input int pre_len, input logic [31:0] body, input logic rel_rd,
                              input int nbits, output logic [31:0] smp);
        logic s;
        smp = '0;
        for (int i = 0; i < pre_len; i++) send_bit(1'b1, 1'b1, s);
        for (int i = 0; i < nbits; i++) begin
            send_bit(!(rel_rd && i >= 14), body[31-i], s);
            smp[31-i] = s;
        end
        master_oe  = 1'b1;
        master_bit = 1'b1;
    endtask

    task automatic run_frame(input string tag, input int pre_len, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] ra,
                             input logic [1:0] ta, input logic [15:0] wd);
        int          we0, re0, en0;
        logic [31:0] smp;
        logic        accept, match, exp_wr, exp_rd;
        we0    = we_cycles;
        re0    = re_cycles;
        en0    = en_cycles;
        accept = (pre_len >= 32);
        match  = accept && (op == 2'b01 || op == 2'b10) && (phy == PHY);
        exp_wr = match && (op == 2'b01) && (ta == 2'b10);
        exp_rd = match && (op == 2'b10);
        send_frame(pre_len, {2'b01, op, phy, ra, ta, wd}, op == 2'b10, 32, smp);
        if (accept) model_addr = ra;
        $display("[TB] frame %s pre=%0d op=%b phy=%0d reg=%0d ta=%b wd=%h rd=%h",
                 tag, pre_len, op, phy, ra, ta, wd, smp[15:0]);
        chk($sformatf("%s_we_cycles", tag), 32'(we_cycles - we0), exp_wr ? 32'd1 : 32'd0);
        chk($sformatf("%s_re_cycles", tag), 32'(re_cycles - re0), exp_rd ? 32'd1 : 32'd0);
        chk($sformatf("%s_mdo_en_cycles", tag), 32'(en_cycles - en0),
            exp_rd ? 32'(RD_EN_CYCLES) : 32'd0);
        chk($sformatf("%s_reg_addr", tag), 32'(tb_bus.reg_addr), 32'(model_addr));
        if (exp_wr) begin
            chk($sformatf("%s_waddr", tag), 32'(last_waddr), 32'(ra));
            chk($sformatf("%s_wdata", tag), 32'(last_wdata), 32'(wd));
            model_mem[ra] = wd;
        end
        if (exp_rd) begin
            chk($sformatf("%s_ta2", tag), 32'(smp[16]), 32'd0);
            chk($sformatf("%s_rdata", tag), 32'(smp[15:0]), 32'(model_mem[ra]));
        end
        chk($sformatf("%s_busy_end", tag), 32'(tb_bus.busy), 32'd0);
        chk($sformatf("%s_mdo_en_end", tag), 32'(tb_bus.mdo_en), 32'd0);
    endtask

    initial begin
        logic [31:0] smp;
        int          we0, en0;
        logic [1:0]  rop;
        logic [4:0]  rphy;

        for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
        model_addr = 5'd0;
        rst_n      = 1'b0;
        tb_bus.mdc = 1'b0;
        master_oe  = 1'b1;
        master_bit = 1'b1;
        #103;                                 // keep MDC edges off the clk edges
        chk("rst_mdo", 32'(tb_bus.mdo), 32'd1);
        chk("rst_mdo_en", 32'(tb_bus.mdo_en), 32'd0);
        chk("rst_reg_addr", 32'(tb_bus.reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(tb_bus.reg_wdata), 32'd0);
        chk("rst_we_re", 32'({tb_bus.reg_we, tb_bus.reg_re}), 32'd0);
        chk("rst_busy", 32'(tb_bus.busy), 32'd0);
        rst_n = 1'b1;
        #100;

        run_frame("wr_beef", 32, 2'b01, PHY, 5'd3, 2'b10, 16'hBEEF);
        run_frame("wr_1234", 32, 2'b01, PHY, 5'd5, 2'b10, 16'h1234);
        run_frame("rd_1234", 32, 2'b10, PHY, 5'd5, 2'b10, 16'h0000);
        run_frame("rd_beef", 32, 2'b10, PHY, 5'd3, 2'b10, 16'h0000);
        run_frame("rd_phy2", 32, 2'b10, 5'd2, 5'd3, 2'b10, 16'h0000);
        run_frame("wr_phy2", 32, 2'b01, 5'd2, 5'd3, 2'b10, 16'hDEAD);
        run_frame("rd_after", 32, 2'b10, PHY, 5'd3, 2'b10, 16'h0000);
        run_frame("wr_pre31", 31, 2'b01, PHY, 5'd7, 2'b10, 16'hAAAA);
        run_frame("rd_pre31", 32, 2'b10, PHY, 5'd7, 2'b10, 16'h0000);
        run_frame("wr_pre32", 32, 2'b01, PHY, 5'd7, 2'b10, 16'hAAAA);
        run_frame("rd_pre32", 32, 2'b10, PHY, 5'd7, 2'b10, 16'h0000);
        run_frame("wr_ta11", 32, 2'b01, PHY, 5'd9, 2'b11, 16'h5555);
        run_frame("op11", 32, 2'b11, PHY, 5'd9, 2'b10, 16'h6666);
        run_frame("rd_reg9", 32, 2'b10, PHY, 5'd9, 2'b10, 16'h0000);

        // MDC stops after REGAD of a read
        we0 = we_cycles;
        en0 = en_cycles;
        send_frame(32, {2'b01, 2'b10, PHY, 5'd11, 2'b10, 16'h0000}, 1'b1, 14, smp);
        model_addr = 5'd11;
        chk("tmo_busy_before", 32'(tb_bus.busy), 32'd1);
        repeat (2100) @(posedge clk);
        #3;
        $display("[TB] timeout after REGAD busy=%0d mdo_en=%0d", tb_bus.busy, tb_bus.mdo_en);
        chk("tmo_busy", 32'(tb_bus.busy), 32'd0);
        chk("tmo_mdo_en", 32'(tb_bus.mdo_en), 32'd0);
        chk("tmo_mdo", 32'(tb_bus.mdo), 32'd1);
        chk("tmo_no_en", 32'(en_cycles - en0), 32'd0);
        chk("tmo_no_we", 32'(we_cycles - we0), 32'd0);
        run_frame("rd_post_tmo", 32, 2'b10, PHY, 5'd11, 2'b10, 16'h0000);

        // Reset lands in the middle of the read data phase, just after the D7 slot
        send_frame(32, {2'b01, 2'b10, PHY, 5'd3, 2'b10, 16'h0000}, 1'b1, 25, smp);
        chk("mid_rd_mdo_en", 32'(tb_bus.mdo_en), 32'd1);
        rst_n = 1'b0;
        #1;
        $display("[TB] reset mid-read mdo_en=%0d mdo=%0d", tb_bus.mdo_en, tb_bus.mdo);
        chk("rstmid_mdo_en", 32'(tb_bus.mdo_en), 32'd0);
        chk("rstmid_mdo", 32'(tb_bus.mdo), 32'd1);
        chk("rstmid_busy", 32'(tb_bus.busy), 32'd0);
        chk("rstmid_reg_addr", 32'(tb_bus.reg_addr), 32'd0);
        model_addr = 5'd0;
        #59;
        rst_n = 1'b1;
        #40;
        run_frame("rd_post_rst", 32, 2'b10, PHY, 5'd3, 2'b10, 16'h0000);

        for (int n = 0; n < 10; n++) begin
            rop  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            rphy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY;
            run_frame($sformatf("rnd%0d", n), 32, rop, rphy, 5'($urandom_range(0, 31)),
                      2'b10, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
